// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver: FSM encoding,
// status bit positions and default parameter values.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned STAT_VALID     = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_FRAME_ERR = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_W         = 4;

  localparam int unsigned TICK_DIV_DEF = 27;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned BUS_W        = 32;
  localparam int unsigned BYTE_W       = 8;

  localparam logic [BUS_W-1:0] ADDR_DATA_DEF = 32'h0000_00F8;
  localparam logic [BUS_W-1:0] ADDR_STAT_DEF = 32'h0000_00FC;

endpackage

// File: rtl/uart_rx_port_if.sv
// Core-side load bus of the UART receiver: address and load strobe in,
// combinational hit/read data and registered rx_valid out.
interface uart_rx_port_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        hit;
  logic [31:0] rdata;
  logic        rx_valid;

  modport master (output addr, rd_en, input hit, rdata, rx_valid);
  modport slave  (input addr, rd_en, output hit, rdata, rx_valid);
endinterface

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle. head_o reads as zero while empty.
module rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             valid_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[head_q];
  assign valid_o = valid_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) tail_q <= tail_q + AW'(1);
      if (do_pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Storage is not reset; empty entries are masked by head_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: 16x oversampled deserializer feeding a
// small FIFO, read by the core through data/status registers.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int unsigned      TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned      DEPTH     = DEPTH_DEF,
  parameter logic [BUS_W-1:0] ADDR_DATA = ADDR_DATA_DEF,
  parameter logic [BUS_W-1:0] ADDR_STAT = ADDR_STAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rxd,
  uart_rx_port_if.slave bus
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              sync1_q, sync2_q;
  logic [TW-1:0]     tick_cnt_q;
  logic              tick;
  rx_state_e         state_q;
  logic [3:0]        os_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] shift_q;
  logic              frame_err_q, overrun_q;
  logic              stop_sample, push, pop, ferr_set, ovr_set, stat_clr;
  logic              sel_data, sel_stat;
  logic              fifo_full, fifo_empty, fifo_valid;
  logic [BYTE_W-1:0] head_data;
  logic [STAT_W-1:0] stat;

  assign tick        = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign stop_sample = (state_q == ST_STOP) && tick && (os_q == 4'd15);
  assign push        = stop_sample && sync2_q;
  assign ferr_set    = stop_sample && !sync2_q;
  assign sel_data    = (bus.addr == ADDR_DATA);
  assign sel_stat    = (bus.addr == ADDR_STAT);
  assign pop         = bus.rd_en && sel_data;
  assign stat_clr    = bus.rd_en && sel_stat;
  assign ovr_set     = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Free-running tick divider, re-phased at each detected start edge.
  always_ff @(posedge clk) begin
    if (rst)                                  tick_cnt_q <= '0;
    else if (state_q == ST_IDLE && !sync2_q)  tick_cnt_q <= '0;
    else if (tick)                            tick_cnt_q <= '0;
    else                                      tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!sync2_q) begin
            state_q <= ST_START;
            os_q    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_q == 4'd7) begin
              os_q    <= '0;
              bit_q   <= '0;
              state_q <= sync2_q ? ST_IDLE : ST_DATA;
            end else begin
              os_q <= os_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_q == 4'd15) begin
              os_q    <= '0;
              shift_q <= {sync2_q, shift_q[BYTE_W-1:1]};
              if (bit_q == 3'd7) state_q <= ST_STOP;
              else               bit_q   <= bit_q + 3'd1;
            end else begin
              os_q <= os_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (os_q == 4'd15) begin
              os_q    <= '0;
              state_q <= sync2_q ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              os_q <= os_q + 4'd1;
            end
          end
        end
        ST_WAIT_HIGH: if (sync2_q) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  // A set in the same cycle as a status-read clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_set || (frame_err_q && !stat_clr);
      overrun_q   <= ovr_set  || (overrun_q   && !stat_clr);
    end
  end

  rx_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (shift_q),
    .head_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .valid_o (fifo_valid)
  );

  always_comb begin
    stat                 = '0;
    stat[STAT_VALID]     = fifo_valid;
    stat[STAT_OVERRUN]   = overrun_q;
    stat[STAT_FRAME_ERR] = frame_err_q;
    stat[STAT_FULL]      = fifo_full;
  end

  assign bus.hit      = sel_data || sel_stat;
  assign bus.rx_valid = fifo_valid;
  assign bus.rdata    = sel_data ? {(BUS_W-BYTE_W)'(0), head_data} :
                        sel_stat ? {(BUS_W-STAT_W)'(0), stat} : '0;

  logic unused_ok;
  assign unused_ok = fifo_empty;
endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: directed frames plus randomized traffic checked
// against a queue-based model of the receiver's registers.
module tb_uart_rx_port;
  import uart_pkg::*;

  localparam int unsigned TDIV  = 2;
  localparam int unsigned BIT_C = 16 * TDIV;
  localparam int unsigned DEP   = 4;
  localparam logic [31:0] A_DAT = 32'h0000_00F8;
  localparam logic [31:0] A_STA = 32'h0000_00FC;

  logic clk = 1'b0;
  logic rst;
  logic rxd;
  int   n_chk = 0;
  int   n_err = 0;

  uart_rx_port_if bus ();

  uart_rx_port #(.TICK_DIV(TDIV), .DEPTH(DEP), .ADDR_DATA(A_DAT), .ADDR_STAT(A_STA)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: received bytes in order plus the two sticky flags.
  logic [7:0] mq [$];
  logic       m_ovr, m_ferr;

  function automatic void m_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void m_frame(input logic [7:0] d, input logic stop_ok);
    if (!stop_ok)               m_ferr = 1'b1;
    else if (mq.size() < DEP)   mq.push_back(d);
    else                        m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    logic [31:0] v;
    v = 32'h0;
    if (a == A_DAT) begin
      if (mq.size() != 0) begin
        v = {24'h0, mq[0]};
        if (rd) void'(mq.pop_front());
      end
    end else if (a == A_STA) begin
      v[3] = (mq.size() == DEP);
      v[2] = m_ferr;
      v[1] = m_ovr;
      v[0] = (mq.size() != 0);
      if (rd) begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; rd=0 observes the register without side effects.
  task automatic bus_cycle(input string tag, input logic [31:0] a, input logic rd);
    logic [31:0] d, e;
    logic        h, v;
    bus.addr  = a;
    bus.rd_en = rd;
    @(negedge clk);
    d = bus.rdata;
    h = bus.hit;
    v = bus.rx_valid;
    check_eq({tag, ".valid"}, 32'(v), 32'(mq.size() != 0));
    e = m_read(a, rd);
    check_eq(tag, d, e);
    check_eq({tag, ".hit"}, 32'(h), 32'((a == A_DAT) || (a == A_STA)));
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.addr  = 32'h0;
  endtask

  // Drives one 10-bit frame cycle by cycle; optionally issues a data read
  // or a one-cycle reset at a given cycle, and reports when rx_valid rose.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_cyc,
                            input int rst_cyc, output logic [31:0] rd_val, output int rise_c);
    logic [9:0] bits;
    logic       prev_v;
    bits   = {stop, d, 1'b0};
    rd_val = 32'h0;
    rise_c = -1;
    prev_v = bus.rx_valid;
    for (int c = 0; c < 10 * int'(BIT_C); c++) begin
      rxd = bits[4'(c / int'(BIT_C))];
      if (c == rd_cyc) begin
        bus.addr  = A_DAT;
        bus.rd_en = 1'b1;
      end
      if (c == rst_cyc) rst = 1'b1;
      @(negedge clk);
      if (c == rd_cyc) rd_val = bus.rdata;
      if (bus.rx_valid && !prev_v && rise_c < 0) rise_c = c;
      prev_v = bus.rx_valid;
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      bus.addr  = 32'h0;
      if (c == rst_cyc) begin
        rst = 1'b0;
        rxd = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_ok(input logic [7:0] d);
    logic [31:0] rv;
    int          rc;
    send_frame(d, 1'b1, -1, -1, rv, rc);
    m_frame(d, 1'b1);
  endtask

  initial begin
    logic [31:0] rv, e;
    int          rc;

    rxd       = 1'b1;
    rst       = 1'b1;
    bus.addr  = 32'h0;
    bus.rd_en = 1'b0;
    m_reset();
    idle(3);
    bus_cycle("rst.stat", A_STA, 1'b1);
    bus_cycle("rst.data", A_DAT, 1'b0);
    bus_cycle("rst.nohit", 32'h0000_00F4, 1'b0);
    rst = 1'b0;
    idle(2);
    check_eq("rst.fsm", 32'(dut.state_q), 32'(ST_IDLE));

    // Single byte, including the cycle rx_valid appears
    send_frame(8'h55, 1'b1, -1, -1, rv, rc);
    m_frame(8'h55, 1'b1);
    check_eq("b55.rise", 32'(rc), 32'd307);
    bus_cycle("b55.stat", A_STA, 1'b1);
    bus_cycle("b55.data", A_DAT, 1'b1);
    bus_cycle("b55.stat2", A_STA, 1'b1);

    // Glitch shorter than half a bit
    rxd = 1'b0;
    idle(6 * TDIV);
    rxd = 1'b1;
    idle(2 * BIT_C);
    check_eq("glitch.fsm", 32'(dut.state_q), 32'(ST_IDLE));
    bus_cycle("glitch.stat", A_STA, 1'b0);

    // Frame error with a held-low line, then recovery
    send_frame(8'hA3, 1'b0, -1, -1, rv, rc);
    m_frame(8'hA3, 1'b0);
    idle(3 * BIT_C);
    bus_cycle("ferr.stat", A_STA, 1'b0);
    rxd = 1'b1;
    idle(BIT_C);
    send_ok(8'h3C);
    bus_cycle("ferr.data", A_DAT, 1'b1);
    bus_cycle("ferr.clr", A_STA, 1'b1);
    bus_cycle("ferr.stat2", A_STA, 1'b1);

    // Overrun: five frames into four entries
    for (int i = 1; i <= 5; i++) send_ok(8'(i));
    bus_cycle("ovr.stat", A_STA, 1'b1);
    for (int i = 0; i < 5; i++) bus_cycle("ovr.data", A_DAT, 1'b1);
    bus_cycle("ovr.stat2", A_STA, 1'b1);

    // Pop in the same cycle as the push into a full FIFO
    for (int i = 1; i <= 4; i++) send_ok(8'(i));
    bus_cycle("sim.pre", A_STA, 1'b0);
    send_frame(8'h05, 1'b1, 306, -1, rv, rc);
    e = m_read(A_DAT, 1'b1);
    m_frame(8'h05, 1'b1);
    check_eq("sim.rd", rv, e);
    bus_cycle("sim.stat", A_STA, 1'b0);
    for (int i = 0; i < 4; i++) bus_cycle("sim.data", A_DAT, 1'b1);
    bus_cycle("sim.stat2", A_STA, 1'b1);

    // Reset during data bit 3 with a byte already queued
    send_ok(8'h11);
    send_frame(8'h99, 1'b1, -1, 4 * int'(BIT_C) + 10, rv, rc);
    m_reset();
    check_eq("mrst.fsm", 32'(dut.state_q), 32'(ST_IDLE));
    bus_cycle("mrst.stat", A_STA, 1'b0);
    bus_cycle("mrst.data", A_DAT, 1'b1);
    idle(2 * BIT_C);
    send_ok(8'hC8);
    bus_cycle("mrst.c8", A_DAT, 1'b1);

    // Randomized traffic with interleaved register accesses
    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      logic       ok;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(d, ok, -1, -1, rv, rc);
      m_frame(d, ok);
      if (!ok) idle($urandom_range(0, 64));
      rxd = 1'b1;
      idle(4 + $urandom_range(0, 40));
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 3))
          0:       bus_cycle("rnd.data", A_DAT, 1'b1);
          1:       bus_cycle("rnd.stat", A_STA, 1'b1);
          2:       bus_cycle("rnd.addr", $urandom, 1'b1);
          default: bus_cycle("rnd.peek", A_STA, 1'b0);
        endcase
      end
    end
    bus_cycle("end.stat", A_STA, 1'b1);
    for (int i = 0; i < int'(DEP) + 1; i++) bus_cycle("end.data", A_DAT, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
